// File: rtl/dm_bus_pkg.sv
// rtl/dm_bus_pkg.sv - region table types, default map and match helper for the OBI decoder
// Contents:
//   region_t        : {base, len} entry of the routing table (held at 64 bits, sliced to ADDR_WIDTH)
//   DEFAULT_MAP     : ROM / GPIO / DEBUG / SRAM map, index 0..3
//   ERR_IDX         : target code of the internal error responder
//   addr_in_region(): unsigned (addr - base) < len test in an aw-bit space
package dm_bus_pkg;

   localparam int unsigned MAP_AW      = 64;
   localparam int unsigned MAX_REGIONS = 16;
   localparam int unsigned TGT_W       = 5;

   // One past the largest slave index, so it never collides with a real port.
   localparam logic [TGT_W-1:0] ERR_IDX = 5'd16;

   typedef struct packed {
      logic [MAP_AW-1:0] base;
      logic [MAP_AW-1:0] len;
   } region_t;

   // Positional pattern on a packed array: leftmost element is index 3.
   localparam region_t [3:0] DEFAULT_MAP = '{
      '{base: 64'h0000_0000, len: 64'h0040_0000},   // 3: SRAM
      '{base: 64'h1A11_0000, len: 64'h0000_1000},   // 2: DEBUG
      '{base: 64'h1A10_1000, len: 64'h0000_1000},   // 1: GPIO
      '{base: 64'h1A00_0000, len: 64'h0010_0000}    // 0: ROM
   };

   // The subtraction wraps inside aw bits, so an address below base yields a
   // huge offset and fails the compare; len==0 disables the entry.
   function automatic logic addr_in_region(input logic [MAP_AW-1:0] addr,
                                           input region_t           r,
                                           input int unsigned       aw);
      logic [MAP_AW-1:0] mask;
      logic [MAP_AW-1:0] off;
      logic [MAP_AW-1:0] len;
      mask = (aw >= MAP_AW) ? '1 : ((MAP_AW'(1) << aw) - MAP_AW'(1));
      off  = (addr - r.base) & mask;
      len  = r.len & mask;
      return (len != '0) && (off < len);
   endfunction

endpackage

// File: rtl/obi_err_responder.sv
// rtl/obi_err_responder.sv - error responder for unmapped OBI accesses plus optional error log
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   gnt_i          : an access to the ERR target was granted this cycle
//   addr_i         : address of the current master request
//   err_clr_i      : clears the error log
//   rvalid_o       : error response, exactly one cycle after each ERR grant
//   err_valid_o    : sticky "unmapped access seen" flag
//   err_addr_o     : address of the first unmapped access since the last clear
// Optional feature macro: OBI_DECODE_ERR_LOG_EN (without it err_valid_o/err_addr_o are 0).
module obi_err_responder #(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  gnt_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic                  err_clr_i,
   output logic                  rvalid_o,
   output logic                  err_valid_o,
   output logic [ADDR_WIDTH-1:0] err_addr_o
);

   // Every ERR grant is answered on the following cycle, so one bit suffices
   // even for back-to-back accesses.
   logic pending_q;
   logic pending_d;

   assign pending_d = gnt_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pending_q <= 1'b0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign rvalid_o = pending_q;

`ifdef OBI_DECODE_ERR_LOG_EN
   logic                  log_valid_q;
   logic                  log_valid_d;
   logic [ADDR_WIDTH-1:0] log_addr_q;
   logic [ADDR_WIDTH-1:0] log_addr_d;

   // Capture takes priority over a clear in the same cycle; once valid, the
   // first logged address is kept until cleared.
   always_comb begin
      log_valid_d = log_valid_q;
      log_addr_d  = log_addr_q;
      if (gnt_i && !log_valid_q) begin
         log_valid_d = 1'b1;
         log_addr_d  = addr_i;
      end else if (err_clr_i) begin
         log_valid_d = 1'b0;
         log_addr_d  = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         log_valid_q <= 1'b0;
         log_addr_q  <= '0;
      end else begin
         log_valid_q <= log_valid_d;
         log_addr_q  <= log_addr_d;
      end
   end

   assign err_valid_o = log_valid_q;
   assign err_addr_o  = log_addr_q;
`else
   logic unused_log;
   assign unused_log  = ^{addr_i, err_clr_i};
   assign err_valid_o = 1'b0;
   assign err_addr_o  = '0;
`endif

endmodule

// File: rtl/obi_region_decoder.sv
// rtl/obi_region_decoder.sv - OBI address decoder/demux from one master to NUM_REGIONS slaves
// Ports:
//   clk_i, rst_i                        : clock, synchronous active-high reset
//   m_req_i/m_gnt_o/m_addr_i/m_we_i/
//   m_be_i/m_wdata_i                    : master request channel
//   m_rvalid_o/m_rdata_o/m_err_o        : master response channel
//   s_req_o/s_gnt_i                     : per-slave request handshake
//   s_addr_o/s_we_o/s_be_o/s_wdata_o    : request fields broadcast to all slaves
//   s_rvalid_i/s_rdata_i/s_err_i        : per-slave responses (s_rdata_i packed, slave 0 in LSBs)
//   err_addr_o/err_valid_o/err_clr_i    : unmapped-access log (OBI_DECODE_ERR_LOG_EN)
// Optional feature macro: OBI_DECODE_ERR_LOG_EN.
module obi_region_decoder
   import dm_bus_pkg::*;
#(
   parameter int unsigned                   NUM_REGIONS     = 4,
   parameter int unsigned                   ADDR_WIDTH      = 32,
   parameter int unsigned                   DATA_WIDTH      = 32,
   parameter int unsigned                   MAX_OUTSTANDING = 2,
   parameter region_t [NUM_REGIONS-1:0]     REGION_MAP      = DEFAULT_MAP
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              m_req_i,
   output logic                              m_gnt_o,
   input  logic [ADDR_WIDTH-1:0]             m_addr_i,
   input  logic                              m_we_i,
   input  logic [DATA_WIDTH/8-1:0]           m_be_i,
   input  logic [DATA_WIDTH-1:0]             m_wdata_i,
   output logic                              m_rvalid_o,
   output logic [DATA_WIDTH-1:0]             m_rdata_o,
   output logic                              m_err_o,
   output logic [NUM_REGIONS-1:0]            s_req_o,
   input  logic [NUM_REGIONS-1:0]            s_gnt_i,
   output logic [ADDR_WIDTH-1:0]             s_addr_o,
   output logic                              s_we_o,
   output logic [DATA_WIDTH/8-1:0]           s_be_o,
   output logic [DATA_WIDTH-1:0]             s_wdata_o,
   input  logic [NUM_REGIONS-1:0]            s_rvalid_i,
   input  logic [NUM_REGIONS*DATA_WIDTH-1:0] s_rdata_i,
   input  logic [NUM_REGIONS-1:0]            s_err_i,
   output logic [ADDR_WIDTH-1:0]             err_addr_o,
   output logic                              err_valid_o,
   input  logic                              err_clr_i
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic [TGT_W-1:0]       target;
   logic [TGT_W-1:0]       tgt_q;
   logic [TGT_W-1:0]       tgt_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic [CNT_W-1:0]       cnt_eff;
   logic                   stall;
   logic                   gnt;
   logic                   err_gnt;
   logic                   err_rvalid;
   logic                   sel_gnt;
   logic                   sel_rvalid;
   logic                   sel_err;
   logic [DATA_WIDTH-1:0]  sel_rdata;
   logic                   rsp_valid;
   logic [NUM_REGIONS-1:0] tgt_mask;

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      target = ERR_IDX;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (addr_in_region(MAP_AW'(m_addr_i), REGION_MAP[i], ADDR_WIDTH)) begin
            target = TGT_W'(i);
         end
      end
   end

   // Grant comes from the decoded target; responses come from the last
   // granted target, which is the only one allowed to have work in flight.
   always_comb begin
      sel_gnt    = 1'b0;
      sel_rvalid = 1'b0;
      sel_err    = 1'b0;
      sel_rdata  = '0;
      tgt_mask   = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         if (target == TGT_W'(i)) begin
            sel_gnt = s_gnt_i[i];
         end
         if (tgt_q == TGT_W'(i)) begin
            tgt_mask[i] = 1'b1;
            sel_rvalid  = s_rvalid_i[i];
            sel_err     = s_err_i[i];
            sel_rdata   = s_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      if (target == ERR_IDX) begin
         sel_gnt = 1'b1;
      end
      if (tgt_q == ERR_IDX) begin
         sel_rvalid = err_rvalid;
         sel_err    = 1'b1;
         sel_rdata  = '0;
      end
   end

   assign rsp_valid = (cnt_q != '0) && sel_rvalid;

   // A response retiring this cycle frees its slot immediately, so a request
   // to a different slave is granted in the same cycle the last response
   // arrives. Switching target only with nothing else in flight keeps
   // responses in order without a FIFO.
   assign cnt_eff = cnt_q - CNT_W'(rsp_valid);
   assign stall   = (cnt_eff == CNT_W'(MAX_OUTSTANDING)) ||
                    ((cnt_eff != '0) && (target != tgt_q));

   assign gnt     = m_req_i && !stall && sel_gnt;
   assign err_gnt = gnt && (target == ERR_IDX);

   always_comb begin
      s_req_o = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         s_req_o[i] = m_req_i && !stall && (target == TGT_W'(i));
      end
   end

   assign m_gnt_o    = gnt;
   assign m_rvalid_o = rsp_valid;
   assign m_rdata_o  = rsp_valid ? sel_rdata : '0;
   assign m_err_o    = rsp_valid && sel_err;

   assign s_addr_o  = m_req_i ? m_addr_i  : '0;
   assign s_we_o    = m_req_i && m_we_i;
   assign s_be_o    = m_req_i ? m_be_i    : '0;
   assign s_wdata_o = m_req_i ? m_wdata_i : '0;

   always_comb begin
      cnt_d = cnt_q;
      tgt_d = tgt_q;
      if (gnt && !rsp_valid) begin
         cnt_d = cnt_q + CNT_W'(1);
         tgt_d = target;
      end else if (!gnt && rsp_valid) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else if (gnt && rsp_valid) begin
         tgt_d = target;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         tgt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         tgt_q <= tgt_d;
      end
   end

   obi_err_responder #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_err_responder (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .gnt_i       (err_gnt),
      .addr_i      (m_addr_i),
      .err_clr_i   (err_clr_i),
      .rvalid_o    (err_rvalid),
      .err_valid_o (err_valid_o),
      .err_addr_o  (err_addr_o)
   );

   // Slaves must answer only while they own the outstanding transactions.
   a_rsp_idle : assert property (@(posedge clk_i) disable iff (rst_i)
      (cnt_q == '0) |-> (s_rvalid_i == '0));
   a_rsp_from_tgt : assert property (@(posedge clk_i) disable iff (rst_i)
      (cnt_q != '0) |-> ((s_rvalid_i & ~tgt_mask) == '0));

endmodule

// File: doc/obi_region_decoder.md
Name: obi_region_decoder

Overview:
- Parametrised OBI address decoder/demux that routes one core-side OBI master port to NUM_REGIONS slave ports, using a base/length region table.
- Supersedes the fixed-map base/length constants as the single point of address routing for the debug/peripheral subsystem.
- Sits between the core data port and peripherals (ROM, GPIO, timer, debug module, SRAM).
- Adds outstanding-transaction tracking, in-order response steering, and an internal error responder for unmapped addresses.

Parameters:
- NUM_REGIONS, 4, number of slave ports / table entries (1..16).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; BE width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (>=1).
- REGION_MAP, dm_bus_pkg::DEFAULT_MAP, array [NUM_REGIONS] of region_t {base, len}.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- m_req_i  in  1  master request
- m_gnt_o  out  1  grant to master
- m_addr_i  in  ADDR_WIDTH  address
- m_we_i  in  1  write enable
- m_be_i  in  DATA_WIDTH/8  byte enables
- m_wdata_i  in  DATA_WIDTH  write data
- m_rvalid_o  out  1  response valid
- m_rdata_o  out  DATA_WIDTH  read data
- m_err_o  out  1  response error
- s_req_o  out  NUM_REGIONS  per-slave request
- s_gnt_i  in  NUM_REGIONS  per-slave grant
- s_addr_o, s_we_o, s_be_o, s_wdata_o  out  broadcast master fields
- s_rvalid_i  in  NUM_REGIONS  per-slave response valid
- s_rdata_i  in  NUM_REGIONS*DATA_WIDTH  per-slave read data
- s_err_i  in  NUM_REGIONS  per-slave error
- err_addr_o  out  ADDR_WIDTH  first unmapped address (optional feature)
- err_valid_o  out  1  sticky decode-error flag (optional feature)
- err_clr_i  in  1  clears err_valid_o/err_addr_o

Behaviour:
- Clock/reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Region match: (addr - base) < len, computed unsigned in ADDR_WIDTH; wrap-around is therefore excluded. A region with len==0 is disabled. On overlap, the lowest index wins.
- Target: the matched index, or ERR (internal responder) when no region matches.
- s_addr_o / s_we_o / s_be_o / s_wdata_o are broadcast combinationally. s_req_o[t] = m_req_i && !stall; m_gnt_o = s_gnt_i[t] && !stall, or 1 for ERR when !stall.
- State: outstanding counter cnt (width clog2(MAX_OUTSTANDING+1)), last target register tgt.
- Stall condition: (cnt==MAX_OUTSTANDING) or (cnt!=0 and target!=tgt). This keeps response order without a FIFO.
- Counter update on grant without response: cnt+1, tgt<=target. On response without grant: cnt-1. On both in the same cycle: cnt unchanged, tgt<=target.
- Response steering: m_rvalid_o / m_rdata_o / m_err_o are muxed combinationally from tgt (0 latency).
  - s_rvalid_i from any non-tgt slave is ignored and flagged by an assertion.
  - Response arriving while cnt==0 is ignored and flagged by an assertion.
- ERR responder: a granted ERR access produces m_rvalid_o=1, m_err_o=1, m_rdata_o=0 exactly 1 cycle after the grant. Back-to-back ERR accesses are accepted every cycle, up to MAX_OUTSTANDING.
- Reset values: cnt=0, tgt=0, ERR pending=0, err_valid_o=0, err_addr_o=0. All outputs are 0 when m_req_i=0 and no response is pending.
- Reset mid-transaction: in-flight responses are dropped and counters are cleared. The slave is responsible for its own reset.

Optional Feature:
- Macro: OBI_DECODE_ERR_LOG_EN.
- Defined: on the first granted ERR access while err_valid_o=0, err_addr_o<=m_addr_i and err_valid_o<=1.
  - Later errors do not overwrite the logged address.
  - err_clr_i clears both registers next cycle; a capture in the same cycle wins over clear.
- Undefined: err_valid_o and err_addr_o are tied to 0 and err_clr_i is ignored.

Decomposition:
- dm_bus_pkg contains:
  - region_t {base, len};
  - DEFAULT_MAP (ROM 0x1A00_0000/0x10_0000, GPIO 0x1A10_1000/0x1000, DEBUG 0x1A11_0000/0x1000, SRAM 0x0000_0000/0x40_0000);
  - addr_in_region() function;
  - the ERR index constant.
- Sub-module obi_err_responder contains the ERR pending register, the response generator and the optional error log.

Test Plan:
- Read 0x1A10_1004 (GPIO, slave 1 grants immediately, rvalid next cycle with rdata 0xDEAD_BEEF) -> s_req_o=4'b0010, m_rdata_o=0xDEAD_BEEF, m_err_o=0.
- Access 0x2000_0000 (unmapped) -> m_gnt_o=1 the same cycle; next cycle m_rvalid_o=1, m_err_o=1, m_rdata_o=0; with macro, err_valid_o=1 and err_addr_o=0x2000_0000.
- Two back-to-back reads to SRAM with delayed responses, then a third read -> third grant stalls until a response arrives; cnt never exceeds 2.
- Read to ROM outstanding, then a request to GPIO -> GPIO req held low until the ROM response; GPIO is granted the cycle the ROM rvalid arrives.
- Overlapping map (region0 0x0/0x1000, region1 0x800/0x1000), access 0x900 -> routed to slave 0.
- rst_i asserted with cnt=2 -> next cycle cnt=0, m_rvalid_o=0, and a new access to any region is granted immediately.
